mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side and RAM-side signals of the shared memory port arbiter
// Fetch:  if_req/if_addr in, if_rdata/if_valid/if_stall out
// Data:   mem_req/mem_w_en/mem_addr/mem_wdata in, mem_rdata/mem_valid/mem_stall out
// Branch: flush in (kills an in-flight fetch result)
// RAM:    ram_addr/ram_wdata/ram_w_en out, ram_rdata in
// Status: busy out
// slave is the arbiter side, master is the pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              mem_req;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic              mem_stall;
  logic              flush;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_w_en;
  logic [31:0]       ram_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, mem_req, mem_w_en, mem_addr, mem_wdata, flush, ram_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_addr, ram_wdata, ram_w_en, busy
  );
  modport master (
    output if_req, if_addr, mem_req, mem_w_en, mem_addr, mem_wdata, flush, ram_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_addr, ram_wdata, ram_w_en, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one single-port RAM
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave) carrying the
// fetch request/response, data request/response, flush, RAM port and busy.
// Data has fixed priority, except that after MAX_DGRANT back-to-back data grants
// with a fetch waiting the fetch is served next.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int MEM_LAT    = 1,
  parameter int MAX_DGRANT = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int DW = $clog2(MAX_DGRANT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPT} state_t;
  state_t            state, state_n;
  logic [DW-1:0]     dcount;
  logic [2:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, if_rdata, mem_rdata;
  logic              we_q, own_d, kill, if_valid, mem_valid;
  logic              grant_d, grant_f, killed;
  always_comb begin
    grant_d = bus.mem_req & (~bus.if_req | (dcount < DW'(MAX_DGRANT)));
    grant_f = ~grant_d & bus.if_req;
    // a flush seen in the capture cycle itself must also suppress the result
    killed  = kill | bus.flush;
    state_n = state;
    unique case (state)
      IDLE:  if (grant_d | grant_f) state_n = ISSUE;
      ISSUE: state_n = we_q ? IDLE : (MEM_LAT == 1 ? CAPT : WAIT);
      WAIT:  if (wcnt <= 3'd1) state_n = CAPT;
      CAPT:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dcount    <= '0;
      wcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      own_d     <= 1'b0;
      kill      <= 1'b0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (state == IDLE && (grant_d || grant_f)) begin
        addr_q <= grant_d ? bus.mem_addr : bus.if_addr;
        we_q   <= grant_d & bus.mem_w_en;
        own_d  <= grant_d;
        if (grant_d) wdata_q <= bus.mem_wdata;
        // only data grants that bypass a waiting fetch count towards starvation
        dcount <= (grant_d & bus.if_req)
                  ? (dcount == DW'(MAX_DGRANT) ? dcount : dcount + 1'b1) : '0;
      end
      wcnt      <= state == ISSUE ? 3'(MEM_LAT - 1) : (state == WAIT ? wcnt - 3'd1 : wcnt);
      kill      <= (state == ISSUE || state == WAIT) & ~own_d & killed;
      mem_valid <= (state == ISSUE & we_q) | (state == CAPT & own_d);
      if_valid  <= state == CAPT & ~own_d & ~killed;
      if (state == CAPT && own_d) mem_rdata <= bus.ram_rdata;
      if (state == CAPT && !own_d && !killed) if_rdata <= bus.ram_rdata;
    end
  end
  assign bus.if_rdata  = if_rdata;
  assign bus.if_valid  = if_valid;
  assign bus.if_stall  = bus.if_req & ~if_valid;
  assign bus.mem_rdata = mem_rdata;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_stall = bus.mem_req & ~mem_valid;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_w_en  = state == ISSUE & we_q;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter with MEM_LAT=3
module tb_mem_port_arbiter;
  localparam int AW = 11, LAT = 3, MAXD = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .MAX_DGRANT(MAXD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  bit [31:0] ram [2048];
  bit [31:0] pipe [LAT];
  bit        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      ram[11'h010] <= 32'hE3A01005;
      ram[11'h044] <= 32'h12345678;
      ram[11'h020] <= 32'hCAFEF00D;
      ram[11'h080] <= 32'h0BADC0DE;
      loaded <= 1'b1;
    end
    if (bus.ram_w_en === 1'b1) ram[bus.ram_addr] <= bus.ram_wdata;
    pipe[0] <= ram[bus.ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[LAT-1];
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // reference model state for the randomized phase
  bit [31:0] shadow [2048];
  int        t_g, t_done, t_addr, dcnt, n;
  bit        t_data, t_w, t_kill, exp_ifv, exp_mv, gd, gf;
  logic [31:0] t_exp, last_if, last_mem;
  bit [7:0]  ord;
  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.mem_req = 0; bus.mem_w_en = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.flush = 0;
    tick; tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_ram_w_en", bus.ram_w_en, 0);
    rst = 0;
    // fetch read, latency LAT+2
    bus.if_req = 1; bus.if_addr = 11'h010;
    #1 chk("f_stall_t0", bus.if_stall, 1);
    tick;
    chk("f_ram_addr", bus.ram_addr, 11'h010);
    chk("f_busy", bus.busy, 1);
    chk("f_ram_w_en", bus.ram_w_en, 0);
    tick; tick; tick;
    chk("f_valid_early", bus.if_valid, 0);
    chk("f_stall_t4", bus.if_stall, 1);
    tick;
    chk("f_valid", bus.if_valid, 1);
    chk("f_rdata", bus.if_rdata, 32'hE3A01005);
    chk("f_stall_done", bus.if_stall, 0);
    chk("f_busy_done", bus.busy, 0);
    bus.if_req = 0;
    tick;
    chk("f_valid_pulse", bus.if_valid, 0);
    // write and fetch together: data first
    bus.mem_req = 1; bus.mem_w_en = 1; bus.mem_addr = 11'h200; bus.mem_wdata = 32'hDEADBEEF;
    bus.if_req = 1; bus.if_addr = 11'h010;
    tick;
    chk("w_ram_w_en", bus.ram_w_en, 1);
    chk("w_ram_addr", bus.ram_addr, 11'h200);
    chk("w_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
    chk("w_mem_stall", bus.mem_stall, 1);
    tick;
    chk("w_ram_w_en_off", bus.ram_w_en, 0);
    chk("w_mem_valid", bus.mem_valid, 1);
    chk("w_mem_stall_done", bus.mem_stall, 0);
    bus.mem_req = 0; bus.mem_w_en = 0;
    tick;
    chk("wf_ram_addr", bus.ram_addr, 11'h010);
    chk("wf_mem_valid_pulse", bus.mem_valid, 0);
    tick; tick; tick;
    chk("wf_valid_early", bus.if_valid, 0);
    tick;
    chk("wf_valid", bus.if_valid, 1);
    chk("wf_rdata", bus.if_rdata, 32'hE3A01005);
    chk("w_ram_content", ram[11'h200], 32'hDEADBEEF);
    bus.if_req = 0;
    tick;
    // data read then fetch
    bus.mem_req = 1; bus.mem_addr = 11'h044; bus.if_req = 1; bus.if_addr = 11'h010;
    chk("r_busy_t0", bus.busy, 0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("r_busy", bus.busy, 1);
      chk("r_mem_valid_early", bus.mem_valid, 0);
    end
    tick;
    chk("r_mem_valid", bus.mem_valid, 1);
    chk("r_mem_rdata", bus.mem_rdata, 32'h12345678);
    chk("r_busy_done", bus.busy, 0);
    bus.mem_req = 0;
    repeat (4) tick;
    chk("rf_valid_early", bus.if_valid, 0);
    tick;
    chk("rf_valid", bus.if_valid, 1);
    bus.if_req = 0;
    tick;
    // starvation bound: D,D,D,F,D,D,D,F
    bus.mem_req = 1; bus.mem_w_en = 0; bus.mem_addr = 11'h044;
    bus.if_req = 1; bus.if_addr = 11'h010;
    n = 0; ord = '0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      tick;
      if (bus.mem_valid === 1'b1) begin ord[7-n] = 1'b1; n++; end
      else if (bus.if_valid === 1'b1) begin ord[7-n] = 1'b0; n++; end
    end
    bus.mem_req = 0; bus.if_req = 0;
    chk("s_count", n, 8);
    chk("s_order", ord, 8'b11101110);
    tick;
    // flush during WAIT of a fetch
    bus.if_req = 1; bus.if_addr = 11'h020;
    tick;
    chk("fl_ram_addr", bus.ram_addr, 11'h020);
    tick;
    bus.flush = 1; bus.if_addr = 11'h080;
    tick;
    bus.flush = 0;
    chk("fl_busy", bus.busy, 1);
    tick;
    chk("fl_valid_capt", bus.if_valid, 0);
    tick;
    chk("fl_valid_killed", bus.if_valid, 0);
    chk("fl_rdata_kept", bus.if_rdata, 32'hE3A01005);
    chk("fl_busy_idle", bus.busy, 0);
    tick;
    chk("fl_reissue_addr", bus.ram_addr, 11'h080);
    chk("fl_reissue_busy", bus.busy, 1);
    tick; tick; tick;
    chk("fl_valid_early", bus.if_valid, 0);
    tick;
    chk("fl_valid", bus.if_valid, 1);
    chk("fl_rdata", bus.if_rdata, 32'h0BADC0DE);
    bus.if_req = 0;
    tick;
    // reset during WAIT of a data read
    bus.mem_req = 1; bus.mem_addr = 11'h044;
    tick; tick;
    rst = 1; bus.mem_req = 0;
    tick;
    rst = 0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_mem_valid", bus.mem_valid, 0);
    chk("mr_mem_rdata", bus.mem_rdata, 0);
    chk("mr_if_rdata", bus.if_rdata, 0);
    chk("mr_ram_addr", bus.ram_addr, 0);
    chk("mr_ram_wdata", bus.ram_wdata, 0);
    chk("mr_ram_w_en", bus.ram_w_en, 0);
    chk("mr_if_valid", bus.if_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("mr_no_valid", bus.mem_valid, 0);
    end
    // randomized phase against a transaction-level model
    for (int i = 0; i < 2048; i++) shadow[i] = ram[i];
    t_g = -1; t_done = -1; t_addr = 0; dcnt = 0; t_data = 0; t_w = 0; t_kill = 0;
    t_exp = '0; last_if = '0; last_mem = '0;
    for (int c = 0; c < 3000; c++) begin
      exp_ifv = (c == t_done) && !t_data && !t_kill;
      exp_mv  = (c == t_done) && t_data;
      if (exp_ifv) last_if = t_exp;
      if (exp_mv && !t_w) last_mem = t_exp;
      chk("rnd_if_valid", bus.if_valid, exp_ifv);
      chk("rnd_mem_valid", bus.mem_valid, exp_mv);
      chk("rnd_if_rdata", bus.if_rdata, last_if);
      chk("rnd_mem_rdata", bus.mem_rdata, last_mem);
      chk("rnd_busy", bus.busy, c > t_g && c < t_done);
      chk("rnd_ram_w_en", bus.ram_w_en, t_w && c == t_g + 1);
      if (c == t_g + 1) begin
        chk("rnd_ram_addr", bus.ram_addr, t_addr);
        if (t_w) chk("rnd_ram_wdata", bus.ram_wdata, t_exp);
      end
      if (exp_ifv) bus.if_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = 11'($urandom_range(0, 31));
      end
      if (exp_mv) begin bus.mem_req = 0; bus.mem_w_en = 0; end
      if (!bus.mem_req && $urandom_range(0, 2) == 0) begin
        bus.mem_req = 1; bus.mem_w_en = 1'($urandom_range(0, 1));
        bus.mem_addr = 11'($urandom_range(0, 31)); bus.mem_wdata = $urandom;
      end
      bus.flush = $urandom_range(0, 7) == 0;
      if (bus.flush) begin
        if (!t_data && c > t_g && c < t_done) t_kill = 1;
        if (bus.if_req) bus.if_addr = 11'($urandom_range(0, 31));
      end
      #1;
      chk("rnd_if_stall", bus.if_stall, bus.if_req && !exp_ifv);
      chk("rnd_mem_stall", bus.mem_stall, bus.mem_req && !exp_mv);
      if (c >= t_done) begin
        gd = bus.mem_req && (!bus.if_req || dcnt < MAXD);
        gf = !gd && bus.if_req;
        if (gd || gf) begin
          t_g = c; t_data = gd; t_w = gd && bus.mem_w_en; t_kill = 0;
          t_addr = gd ? int'(bus.mem_addr) : int'(bus.if_addr);
          t_done = c + (t_w ? 2 : LAT + 2);
          t_exp = t_w ? bus.mem_wdata : shadow[t_addr];
          if (t_w) shadow[t_addr] = bus.mem_wdata;
          dcnt = (gd && bus.if_req) ? (dcnt < MAXD ? dcnt + 1 : MAXD) : 0;
        end
      end
      tick;
    end
    bus.flush = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
